// File: rtl/sid_audio_pkg.sv
// Shared SID audio definitions: mode bits, midscale,
// mixer FSM states and the 14->8 bit saturation helper.
package sid_audio_pkg;

  localparam int MODE_LP = 0;
  localparam int MODE_BP = 1;
  localparam int MODE_HP = 2;

  localparam logic [7:0] PCM_MIDSCALE = 8'h80;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUM,
    S_MUL,
    S_OUT
  } state_e;

  function automatic logic [7:0] sat8(
    input logic signed [13:0] v
  );
    if (v > 14'sd127) begin
      return 8'h7F;
    end else if (v < -14'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/sid_output_mixer_if.sv
// Sample-in / PCM-out bundle of the SID output mixer.
// The master drives samples; the slave is the mixer.
interface sid_output_mixer_if;

  logic              sample_valid;
  logic signed [7:0] filt_hp;
  logic signed [7:0] filt_bp;
  logic signed [7:0] filt_lp;
  logic signed [7:0] bypass_in;
  logic [2:0]        mode;
  logic [3:0]        volume;
  logic [7:0]        pcm_out;
  logic              pcm_valid;
  logic              pwm_out;
  logic              busy;
  logic              overrun;

  modport master (
    output sample_valid, filt_hp, filt_bp, filt_lp,
    output bypass_in, mode, volume,
    input  pcm_out, pcm_valid, pwm_out, busy, overrun
  );

  modport slave (
    input  sample_valid, filt_hp, filt_bp, filt_lp,
    input  bypass_in, mode, volume,
    output pcm_out, pcm_valid, pwm_out, busy, overrun
  );

endinterface

// File: rtl/sid_pwm_dac.sv
// PWM DAC: free-running counter, left-aligned duty that
// reloads only at the period end, registered compare.
module sid_pwm_dac #(
  parameter int PWM_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pcm_in,
  output logic       pwm_out
);

  localparam logic [PWM_BITS-1:0] DUTY_RST =
    PWM_BITS'(8'h80) << (PWM_BITS - 8);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d  = cnt_q + PWM_BITS'(1);
    duty_d = duty_q;
    if (&cnt_q) begin
      duty_d = PWM_BITS'(pcm_in) << (PWM_BITS - 8);
    end
    pwm_d = (cnt_q < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      duty_q <= DUTY_RST;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/sid_output_mixer.sv
// SID output mixer: mode-selected filter mix plus bypass,
// serial 4-bit volume multiply, offset-binary PCM and PWM.
module sid_output_mixer
  import sid_audio_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input logic               clk,
  input logic               rst_n,
  sid_output_mixer_if.slave bus
);

  state_e            state_q, state_d;
  logic signed [7:0] hp_q, hp_d;
  logic signed [7:0] bp_q, bp_d;
  logic signed [7:0] lp_q, lp_d;
  logic signed [7:0] byp_q, byp_d;
  logic [2:0]        mode_q, mode_d;
  logic [3:0]        vol_q, vol_d;
  logic signed [9:0] sum_q, sum_d;
  logic signed [13:0] acc_q, acc_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        pcm_q, pcm_d;
  logic              pcm_valid_q, pcm_valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic signed [13:0] sum_ext;
  logic signed [13:0] res;

  assign sum_ext = {{4{sum_q[9]}}, sum_q};
  assign res     = acc_q >>> 4;

  function automatic logic signed [9:0] term(
    input logic signed [7:0] v,
    input logic              en
  );
    return en ? {{2{v[7]}}, v} : 10'sd0;
  endfunction

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    bp_d        = bp_q;
    lp_d        = lp_q;
    byp_d       = byp_q;
    mode_d      = mode_q;
    vol_d       = vol_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q |
                  (bus.sample_valid & (state_q != S_IDLE));
    unique case (state_q)
      S_IDLE: begin
        if (bus.sample_valid) begin
          hp_d    = bus.filt_hp;
          bp_d    = bus.filt_bp;
          lp_d    = bus.filt_lp;
          byp_d   = bus.bypass_in;
          mode_d  = bus.mode;
          vol_d   = bus.volume;
          busy_d  = 1'b1;
          state_d = S_SUM;
        end
      end
      S_SUM: begin
        sum_d = term(byp_q, 1'b1)
              + term(lp_q, mode_q[MODE_LP])
              + term(bp_q, mode_q[MODE_BP])
              + term(hp_q, mode_q[MODE_HP]);
        acc_d   = '0;
        idx_d   = 2'd3;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (vol_q[idx_q]) begin
          acc_d = acc_q + (sum_ext <<< idx_q);
        end
        if (idx_q == 2'd0) begin
          state_d = S_OUT;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
      S_OUT: begin
        pcm_d       = sat8(res) ^ PCM_MIDSCALE;
        pcm_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hp_q        <= '0;
      bp_q        <= '0;
      lp_q        <= '0;
      byp_q       <= '0;
      mode_q      <= '0;
      vol_q       <= '0;
      sum_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      pcm_q       <= PCM_MIDSCALE;
      pcm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      bp_q        <= bp_d;
      lp_q        <= lp_d;
      byp_q       <= byp_d;
      mode_q      <= mode_d;
      vol_q       <= vol_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  sid_pwm_dac #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .pcm_in  (pcm_q),
    .pwm_out (bus.pwm_out)
  );

  assign bus.pcm_out   = pcm_q;
  assign bus.pcm_valid = pcm_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sid_output_mixer.sv
// Bench for sid_output_mixer: vector table, random samples
// against an arithmetic model, overrun, reset and PWM cases.
module tb_sid_output_mixer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sid_output_mixer_if bus ();

  sid_output_mixer #(
    .PWM_BITS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] hp;
    logic signed [7:0] bp;
    logic signed [7:0] lp;
    logic signed [7:0] byp;
    logic [2:0]        mode;
    logic [3:0]        vol;
    logic [7:0]        exp;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, got, got, exp, exp);
    end
  endtask

  // Mix, scale by volume/16 rounding toward -inf, clamp, offset.
  function automatic logic [7:0] model(input int hp, input int bp,
                                       input int lp, input int byp,
                                       input logic [2:0] mode,
                                       input int vol);
    int s, p, r;
    s = byp;
    if (mode[0]) s += lp;
    if (mode[1]) s += bp;
    if (mode[2]) s += hp;
    p = s * vol;
    r = p / 16;
    if (p < 0 && (p % 16) != 0) r -= 1;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r + 128);
  endfunction

  task automatic drive(input vec_t v);
    bus.filt_hp      = v.hp;
    bus.filt_bp      = v.bp;
    bus.filt_lp      = v.lp;
    bus.bypass_in    = v.byp;
    bus.mode         = v.mode;
    bus.volume       = v.vol;
    bus.sample_valid = 1'b1;
  endtask

  task automatic scramble();
    bus.filt_hp   = 8'($urandom);
    bus.filt_bp   = 8'($urandom);
    bus.filt_lp   = 8'($urandom);
    bus.bypass_in = 8'($urandom);
    bus.mode      = 3'($urandom);
    bus.volume    = 4'($urandom);
  endtask

  // Call right after drive() at a negedge; waits for the result.
  task automatic collect(input logic [7:0] exp, input string nm,
                         input bit scr);
    int c;
    for (c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.sample_valid = 1'b0;
        check({nm, " busy"}, int'(bus.busy), 1);
      end
      if (scr && c == 2) scramble();
      if (bus.pcm_valid) break;
    end
    check({nm, " latency"}, c, 7);
    check({nm, " pcm"}, int'(bus.pcm_out), int'(exp));
  endtask

  function automatic vec_t mk(input int hp, input int bp, input int lp,
                              input int byp, input int mode,
                              input int vol, input int exp);
    vec_t v;
    v.hp   = 8'(hp);
    v.bp   = 8'(bp);
    v.lp   = 8'(lp);
    v.byp  = 8'(byp);
    v.mode = 3'(mode);
    v.vol  = 4'(vol);
    v.exp  = 8'(exp);
    return v;
  endfunction

  initial begin
    vec_t v;
    int   cnt;
    bit   seen;
    checks = 0;
    errors = 0;

    vt[0] = mk(0, 0, 0, 40, 0, 15, 'hA5);
    vt[1] = mk(127, 127, 127, 127, 7, 15, 'hFF);
    vt[2] = mk(0, 0, -128, -128, 1, 15, 'h00);
    vt[3] = mk(100, -50, 77, 90, 7, 0, 'h80);
    vt[4] = mk(0, 10, 0, -20, 2, 8, 'h7B);
    vt[5] = mk(-1, 0, 0, 0, 4, 1, 'h7F);
    vt[6] = mk(50, 100, 77, 3, 6, 5, 'hAF);

    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.filt_hp      = '0;
    bus.filt_bp      = '0;
    bus.filt_lp      = '0;
    bus.bypass_in    = '0;
    bus.mode         = '0;
    bus.volume       = '0;
    repeat (3) @(negedge clk);
    check("rst pcm_out", int'(bus.pcm_out), 'h80);
    check("rst pcm_valid", int'(bus.pcm_valid), 0);
    check("rst pwm_out", int'(bus.pwm_out), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst overrun", int'(bus.overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      drive(vt[i]);
      collect(vt[i].exp, $sformatf("vec%0d", i), 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d strobe_end", i), int'(bus.pcm_valid), 0);
      check($sformatf("vec%0d busy_end", i), int'(bus.busy), 0);
    end

    // Back-to-back at minimum spacing, inputs disturbed in flight.
    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 7), $urandom_range(0, 15), 0);
      v.exp = model(int'(v.hp), int'(v.bp), int'(v.lp), int'(v.byp),
                    v.mode, int'(v.vol));
      drive(v);
      collect(v.exp, $sformatf("rnd%0d", i), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    check("overrun clean", int'(bus.overrun), 0);

    // Overrun: second strobe 3 cycles in is dropped.
    @(negedge clk);
    drive(vt[0]);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    drive(vt[1]);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("ovr set", int'(bus.overrun), 1);
    repeat (2) begin
      @(negedge clk);
      check("ovr no early valid", int'(bus.pcm_valid), 0);
    end
    @(negedge clk);
    check("ovr first valid", int'(bus.pcm_valid), 1);
    check("ovr first pcm", int'(bus.pcm_out), int'(vt[0].exp));
    drive(vt[4]);
    collect(vt[4].exp, "ovr next", 1'b0);
    check("ovr sticky", int'(bus.overrun), 1);

    // Asynchronous reset while multiplying.
    @(negedge clk);
    drive(vt[1]);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst pcm_out", int'(bus.pcm_out), 'h80);
    check("mrst busy", int'(bus.busy), 0);
    check("mrst pcm_valid", int'(bus.pcm_valid), 0);
    check("mrst overrun", int'(bus.overrun), 0);
    check("mrst pwm_out", int'(bus.pwm_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.pcm_valid) seen = 1'b1;
    end
    check("mrst no valid", int'(seen), 0);
    drive(vt[5]);
    collect(vt[5].exp, "mrst next", 1'b0);

    // PWM: duty 0x40, then change mid-period to 0xC0.
    @(negedge clk);
    v = mk(0, 0, 0, -128, 0, 8, 'h40);
    drive(v);
    collect(v.exp, "pwm set40", 1'b0);
    repeat (260) @(negedge clk);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.pwm_out) cnt++;
    end
    check("pwm 0x40 window", cnt, 64);

    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!bus.pwm_out) seen = 1'b1;
      else if (seen) break;
    end
    check("pwm rise found", int'(bus.pwm_out), 1);
    v = mk(0, 0, 64, 64, 1, 8, 'hC0);
    cnt = 0;
    for (int j = 0; j < 256; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 21) bus.sample_valid = 1'b0;
      if (bus.pwm_out) cnt++;
      if (j == 20) drive(v);
    end
    check("pwm old period", cnt, 64);
    check("pwm new pcm", int'(bus.pcm_out), 'hC0);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.pwm_out) cnt++;
    end
    check("pwm new period", cnt, 192);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
